// File: rtl/cpu_pkg.sv
// Encodings shared by the execution datapath and the fetch/decode/execute control FSM.
package cpu_pkg;

    typedef enum logic [1:0] {
        SUM = 2'b00,
        RES = 2'b01,
        MOV = 2'b10,
        OUT = 2'b11
    } opcode_t;

    // Memory address source: the upper bit picks operand field B over field A.
    typedef enum logic [1:0] {
        SEL_DEF = 2'b00,
        SEL_A   = 2'b01,
        SEL_B   = 2'b10,
        SEL_BW  = 2'b11
    } selmux_t;

    // Control FSM states: fetch, decode, read op1, read op2, execute/write, output.
    typedef enum logic [2:0] {
        F  = 3'd0,
        D  = 3'd1,
        R1 = 3'd2,
        R2 = 3'd3,
        X  = 3'd4,
        OA = 3'd5
    } state_t;

endpackage

// File: rtl/data_mem_rf.sv
// Register-based data memory: one combinational read port, core write port,
// and a boot/debug write port that yields to the core write whenever both fire.
module data_mem_rf
    import cpu_pkg::*;
#(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_data,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    assign rdata = mem[raddr];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2**AW; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end else if (dbg_we) begin
            mem[dbg_addr] <= dbg_data;
        end
    end

endmodule

// File: rtl/datapath_exec.sv
// Execution datapath driven by the control word of the FSM: PC, IR, operands,
// data memory, ALU and a valid/ready output register with sticky error flags.
module datapath_exec
    import cpu_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = 4,
    parameter int PW = 6,
    localparam int IW = 2 + 2*AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enir,
    input  logic          enrop1,
    input  logic          enrop2,
    input  logic          enmem,
    input  logic          enrio,
    input  logic          enpc,
    input  logic [1:0]    seloper,
    input  logic [1:0]    selmux,
    output logic [1:0]    operacion,
    output logic [PW-1:0] prog_addr,
    input  logic [IW-1:0] prog_data,
    output logic [DW-1:0] io_data,
    output logic          io_valid,
    input  logic          io_ready,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_data,
    output logic          err,
    output logic          ovf
);

    logic [PW-1:0] pc;
    logic [IW-1:0] ir;
    logic [DW-1:0] op1, op2;
    logic [DW-1:0] alu;
    logic [DW-1:0] rdata;
    logic [AW-1:0] field_a, field_b, maddr;
    opcode_t       opcode;

    assign opcode    = opcode_t'(ir[IW-1:IW-2]);
    assign field_a   = ir[2*AW-1:AW];
    assign field_b   = ir[AW-1:0];
    assign operacion = opcode;
    assign prog_addr = pc;

    always_comb begin
        maddr = field_a;
        case (selmux_t'(selmux))
            SEL_B, SEL_BW: maddr = field_b;
            default:       maddr = field_a;
        endcase
    end

    // ALU follows the latched opcode; seloper is only cross-checked against it.
    always_comb begin
        alu = op1;
        case (opcode)
            SUM:     alu = op1 + op2;
            RES:     alu = op1 - op2;
            default: alu = op1;
        endcase
    end

    data_mem_rf #(.AW(AW), .DW(DW)) u_mem (
        .clk      (clk),
        .rst      (rst),
        .we       (enmem),
        .waddr    (maddr),
        .wdata    (alu),
        .dbg_we   (dbg_we),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .raddr    (maddr),
        .rdata    (rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= '0;
            ir       <= '0;
            op1      <= '0;
            op2      <= '0;
            io_data  <= '0;
            io_valid <= 1'b0;
            err      <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            if (enir)   ir  <= prog_data;
            if (enrop1) op1 <= rdata;
            if (enrop2) begin
                op2 <= rdata;
                if (seloper != opcode) err <= 1'b1;
            end
            if (enpc)   pc  <= pc + 1'b1;
            // A new load in the same cycle as a handshake keeps valid high.
            if (enrio) begin
                io_data  <= rdata;
                io_valid <= 1'b1;
                if (io_valid && !io_ready) ovf <= 1'b1;
            end else if (io_valid && io_ready) begin
                io_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_datapath_exec.sv
// Directed bench for datapath_exec: hand-computed results for each instruction,
// output handshake, sticky flags, PC wrap, write collision and reset override.
module tb_datapath_exec;
    import cpu_pkg::*;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int PW = 6;
    localparam int IW = 2 + 2*AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enir = 0, enrop1 = 0, enrop2 = 0, enmem = 0, enrio = 0, enpc = 0;
    logic [1:0]    seloper = 2'b00, selmux = 2'b00;
    logic [1:0]    operacion;
    logic [PW-1:0] prog_addr;
    logic [IW-1:0] prog_data;
    logic [DW-1:0] io_data;
    logic          io_valid;
    logic          io_ready = 1'b0;
    logic          dbg_we = 1'b0;
    logic [AW-1:0] dbg_addr = '0;
    logic [DW-1:0] dbg_data = '0;
    logic          err, ovf;

    logic [IW-1:0] rom [2**PW];
    int checks = 0;
    int errors = 0;

    assign prog_data = rom[prog_addr];

    always #5 clk = ~clk;

    datapath_exec #(.DW(DW), .AW(AW), .PW(PW)) dut (
        .clk(clk), .rst(rst),
        .enir(enir), .enrop1(enrop1), .enrop2(enrop2), .enmem(enmem),
        .enrio(enrio), .enpc(enpc), .seloper(seloper), .selmux(selmux),
        .operacion(operacion), .prog_addr(prog_addr), .prog_data(prog_data),
        .io_data(io_data), .io_valid(io_valid), .io_ready(io_ready),
        .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .err(err), .ovf(ovf)
    );

    function automatic logic [IW-1:0] mk(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        return {op, a, b};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        enir = 0; enrop1 = 0; enrop2 = 0; enmem = 0; enrio = 0; enpc = 0;
        dbg_we = 0;
    endtask

    task automatic dbg_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        dbg_we = 1; dbg_addr = a; dbg_data = d;
        cyc();
        dbg_we = 0;
    endtask

    task automatic fetch();
        enir = 1; enpc = 1;
        cyc();
        idle();
    endtask

    initial begin
        for (int i = 0; i < 2**PW; i++) rom[i] = '0;
        rom[0] = mk(2'b00, 4'd2, 4'd3);
        rom[1] = mk(2'b01, 4'd1, 4'd4);
        rom[2] = mk(2'b10, 4'd6, 4'd9);
        rom[3] = mk(2'b11, 4'd9, 4'd3);

        cyc(); cyc();
        rst = 0;
        chk("rst_pc", 32'(prog_addr), 0);
        chk("rst_valid", 32'(io_valid), 0);
        chk("rst_data", 32'(io_data), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_ovf", 32'(ovf), 0);

        dbg_write(4'd2, 8'h7F);
        dbg_write(4'd3, 8'h02);
        dbg_write(4'd1, 8'h05);
        dbg_write(4'd4, 8'h07);
        dbg_write(4'd6, 8'hA5);
        chk("dbg_mem2", 32'(dut.u_mem.mem[2]), 32'h7F);

        // SUM A=2 B=3
        fetch();
        chk("sum_opcode", 32'(operacion), 0);
        chk("sum_pc", 32'(prog_addr), 1);
        enrop1 = 1; selmux = 2'b01; cyc(); idle();
        enrop2 = 1; selmux = 2'b10; seloper = 2'b00; cyc(); idle();
        enmem = 1; selmux = 2'b11; cyc(); idle();
        chk("sum_mem3", 32'(dut.u_mem.mem[3]), 32'h81);
        chk("sum_err", 32'(err), 0);

        // RES A=1 B=4, seloper deliberately wrong
        fetch();
        chk("res_opcode", 32'(operacion), 1);
        enrop1 = 1; selmux = 2'b01; cyc(); idle();
        enrop2 = 1; selmux = 2'b10; seloper = 2'b00; cyc(); idle();
        chk("res_err", 32'(err), 1);
        enmem = 1; selmux = 2'b11; cyc(); idle();
        chk("res_mem4", 32'(dut.u_mem.mem[4]), 32'hFE);

        // MOV A=6 B=9
        fetch();
        enrop1 = 1; selmux = 2'b00; cyc(); idle();
        enrop2 = 1; selmux = 2'b10; seloper = 2'b10; cyc(); idle();
        enmem = 1; selmux = 2'b11; cyc(); idle();
        chk("mov_mem9", 32'(dut.u_mem.mem[9]), 32'hA5);
        chk("mov_err_sticky", 32'(err), 1);

        // OUT A=9 B=3
        fetch();
        chk("out_opcode", 32'(operacion), 3);
        io_ready = 0;
        enrio = 1; selmux = 2'b00; cyc(); idle();
        chk("out_data", 32'(io_data), 32'hA5);
        chk("out_valid", 32'(io_valid), 1);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("hold_data", 32'(io_data), 32'hA5);
            chk("hold_valid", 32'(io_valid), 1);
        end
        io_ready = 1; cyc(); io_ready = 0;
        chk("drain_valid", 32'(io_valid), 0);
        chk("drain_ovf", 32'(ovf), 0);

        // Reload with ready high in the same cycle: no overflow
        enrio = 1; selmux = 2'b00; cyc(); idle();
        chk("reload_valid", 32'(io_valid), 1);
        io_ready = 1; enrio = 1; selmux = 2'b11; cyc(); idle(); io_ready = 0;
        chk("accept_data", 32'(io_data), 32'h81);
        chk("accept_valid", 32'(io_valid), 1);
        chk("accept_ovf", 32'(ovf), 0);

        // Overwrite with ready low: overflow
        enrio = 1; selmux = 2'b00; cyc(); idle();
        chk("ovf_data", 32'(io_data), 32'hA5);
        chk("ovf_flag", 32'(ovf), 1);
        chk("ovf_valid", 32'(io_valid), 1);

        // PC wrap (pc is 4 here)
        enpc = 1;
        repeat (59) cyc();
        chk("pc_63", 32'(prog_addr), 63);
        cyc();
        enpc = 0;
        chk("pc_wrap", 32'(prog_addr), 0);

        // Write collision: MOV A=5, op1 still holds A5
        rom[0] = mk(2'b10, 4'd5, 4'd0);
        enir = 1; cyc(); idle();
        enmem = 1; selmux = 2'b00;
        dbg_we = 1; dbg_addr = 4'd5; dbg_data = 8'h3C;
        cyc(); idle();
        chk("coll_same", 32'(dut.u_mem.mem[5]), 32'hA5);
        enmem = 1; selmux = 2'b00;
        dbg_we = 1; dbg_addr = 4'd7; dbg_data = 8'h3C;
        cyc(); idle();
        chk("coll_diff", 32'(dut.u_mem.mem[7]), 32'h00);

        // Reset overrides enables mid-instruction
        rst = 1; enpc = 1; enmem = 1; enrio = 1; enir = 1;
        dbg_we = 1; dbg_addr = 4'd8; dbg_data = 8'h11;
        cyc();
        rst = 0; idle();
        chk("rst2_pc", 32'(prog_addr), 0);
        chk("rst2_op", 32'(operacion), 0);
        chk("rst2_valid", 32'(io_valid), 0);
        chk("rst2_err", 32'(err), 0);
        chk("rst2_ovf", 32'(ovf), 0);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("rst2_mem%0d", i), 32'(dut.u_mem.mem[i]), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
